// File: rtl/enemy_shot.sv
// ---------------------------------------------------------------------------
// enemy_shot
//
// Enemy projectile unit. It watches the shooter selection coming from the game
// engine. When the selection changes, it spawns one shot under the chosen
// enemy. The shot falls SHOT_SPEED pixels per frame until it leaves the screen
// or hits the player. Each hit removes one life. When the last life is lost,
// the player is reported dead back to the engine.
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous reset, active low
//   restart          in   synchronous game restart, active high
//   frame_tick       in   one-cycle pulse per video frame
//   ID_enemy_tiro_X  in   [5:0] linear index of the shooting enemy
//   ID_enemy_tiro_Y  in   [5:0] row of the shooting enemy
//   grid_x, grid_y   in   [9:0] top-left corner of the enemy grid
//   player_x         in   [9:0] left edge of the player sprite
//   shot_active      out  shot is on screen
//   shot_x, shot_y   out  [9:0] top position of the shot
//   hit_pulse        out  one-cycle pulse when the player is hit
//   lives            out  [1:0] remaining lives
//   jogador_vivo     out  player alive
// ---------------------------------------------------------------------------
module enemy_shot #(
  parameter int ENEMY_COLS = 8,
  parameter int SPACING_X  = 40,
  parameter int SPACING_Y  = 32,
  parameter int ENEMY_W    = 24,
  parameter int ENEMY_H    = 16,
  parameter int SHOT_H     = 8,
  parameter int SHOT_SPEED = 4,
  parameter int SCREEN_H   = 480,
  parameter int PLAYER_Y   = 440,
  parameter int PLAYER_W   = 32,
  parameter int PLAYER_H   = 16,
  parameter int LIVES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       frame_tick,
  input  logic [5:0] ID_enemy_tiro_X,
  input  logic [5:0] ID_enemy_tiro_Y,
  input  logic [9:0] grid_x,
  input  logic [9:0] grid_y,
  input  logic [9:0] player_x,
  output logic       shot_active,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       hit_pulse,
  output logic [1:0] lives,
  output logic       jogador_vivo
);

  localparam logic [15:0] COLS16     = 16'(ENEMY_COLS);
  localparam logic [15:0] SPX16      = 16'(SPACING_X);
  localparam logic [15:0] SPY16      = 16'(SPACING_Y);
  localparam logic [9:0]  X_OFF      = 10'(ENEMY_W / 2);
  localparam logic [9:0]  Y_OFF      = 10'(ENEMY_H);
  localparam logic [10:0] SPEED11    = 11'(SHOT_SPEED);
  localparam logic [10:0] SHOT_H11   = 11'(SHOT_H);
  localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);
  localparam logic [10:0] P_TOP11    = 11'(PLAYER_Y);
  localparam logic [10:0] P_BOT11    = 11'(PLAYER_Y + PLAYER_H);
  localparam logic [10:0] P_W11      = 11'(PLAYER_W);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLY,
    S_HIT,
    S_DEAD
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] prev_id_q;
  logic [11:0] pend_id_q, pend_id_d;
  logic        pend_q, pend_d;
  logic        shot_active_q, shot_active_d;
  logic [9:0]  shot_x_q, shot_x_d;
  logic [9:0]  shot_y_q, shot_y_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic [1:0]  lives_q, lives_d;
  logic        vivo_q, vivo_d;

  logic [11:0] cur_id;
  logic        id_change;
  logic [15:0] pend_x16, pend_y16;
  logic [15:0] row_base, col_wide;
  logic        col_ok;
  logic [9:0]  spawn_x, spawn_y;
  logic [10:0] next_y;
  logic        miss, x_in, y_in;

  assign cur_id    = {ID_enemy_tiro_X, ID_enemy_tiro_Y};
  assign id_change = (cur_id != prev_id_q);

  // Column decode is done in 16 bits so that X < Y*ENEMY_COLS is caught
  // explicitly instead of wrapping into a small, seemingly valid column.
  assign pend_x16 = {10'd0, pend_id_q[11:6]};
  assign pend_y16 = {10'd0, pend_id_q[5:0]};
  assign row_base = pend_y16 * COLS16;
  assign col_wide = pend_x16 - row_base;
  assign col_ok   = (pend_x16 >= row_base) && (col_wide < COLS16);

  // Spawn position wraps at 10 bits like the rest of the screen coordinates.
  assign spawn_x = grid_x + 10'(col_wide * SPX16) + X_OFF;
  assign spawn_y = grid_y + 10'(pend_y16 * SPY16) + Y_OFF;

  // Movement and collision use one extra bit so that a shot close to the
  // bottom cannot wrap back to the top of the screen.
  assign next_y = {1'b0, shot_y_q} + SPEED11;
  assign miss   = (next_y >= SCREEN_H11);
  assign x_in   = ({1'b0, shot_x_q} >= {1'b0, player_x}) &&
                  ({1'b0, shot_x_q} <  ({1'b0, player_x} + P_W11));
  assign y_in   = ((next_y + SHOT_H11) > P_TOP11) && (next_y < P_BOT11);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_id_d     = pend_id_q;
    shot_active_d = shot_active_q;
    shot_x_d      = shot_x_q;
    shot_y_d      = shot_y_q;
    hit_pulse_d   = 1'b0;
    lives_d       = lives_q;
    vivo_d        = vivo_q;

    // Single-entry request slot: the most recent change always wins.
    if (id_change) begin
      pend_d    = 1'b1;
      pend_id_d = cur_id;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // A change arriving in this same cycle is a new request and must
        // survive the consume.
        if (!id_change) begin
          pend_d = 1'b0;
        end
        if (col_ok) begin
          shot_x_d      = spawn_x;
          shot_y_d      = spawn_y;
          shot_active_d = 1'b1;
          state_d       = S_FLY;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FLY: begin
        if (frame_tick) begin
          if (miss) begin
            shot_active_d = 1'b0;
            state_d       = S_IDLE;
          end else if (x_in && y_in) begin
            shot_active_d = 1'b0;
            hit_pulse_d   = 1'b1;
            if (lives_q != 2'd0) begin
              lives_d = lives_q - 2'd1;
            end
            state_d = S_HIT;
          end else begin
            shot_y_d = next_y[9:0];
          end
        end
      end

      S_HIT: begin
        if (lives_q == 2'd0) begin
          vivo_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = S_DEAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DEAD: begin
        pend_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      prev_id_q     <= 12'd0;
      pend_q        <= 1'b0;
      pend_id_q     <= 12'd0;
      shot_active_q <= 1'b0;
      shot_x_q      <= 10'd0;
      shot_y_q      <= 10'd0;
      hit_pulse_q   <= 1'b0;
      lives_q       <= LIVES_INIT;
      vivo_q        <= 1'b1;
    end else if (restart) begin
      state_q       <= S_IDLE;
      prev_id_q     <= 12'd0;
      pend_q        <= 1'b0;
      pend_id_q     <= 12'd0;
      shot_active_q <= 1'b0;
      shot_x_q      <= 10'd0;
      shot_y_q      <= 10'd0;
      hit_pulse_q   <= 1'b0;
      lives_q       <= LIVES_INIT;
      vivo_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      prev_id_q     <= cur_id;
      pend_q        <= pend_d;
      pend_id_q     <= pend_id_d;
      shot_active_q <= shot_active_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
      hit_pulse_q   <= hit_pulse_d;
      lives_q       <= lives_d;
      vivo_q        <= vivo_d;
    end
  end

  assign shot_active  = shot_active_q;
  assign shot_x       = shot_x_q;
  assign shot_y       = shot_y_q;
  assign hit_pulse    = hit_pulse_q;
  assign lives        = lives_q;
  assign jogador_vivo = vivo_q;

endmodule
